vga_sync_receiver: RTL and testbench
====================================

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 Parameter PERIODO_H, default 1600, meaning expected clocks between consecutive HSync rising edges.
REQ-002 Parameter ANCHO_H, default 1408, meaning expected clocks HSync stays high per line.
REQ-003 Parameter LOCK_CNT, default 2, meaning consecutive matching lines required to declare lock.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 HSync  input  1  incoming horizontal sync; positive pulse, asynchronous to clk.
REQ-007 VSync  input  1  incoming vertical sync; positive pulse, asynchronous to clk.
REQ-008 cntHorizontalRec  output  11  recovered horizontal counter matching the transmitter's count, where HSync is high for counts 1..1408.
REQ-009 cntVerticalRec  output  10  recovered line counter within the frame.
REQ-010 periodoH  output  11  last measured line period, in clocks.
REQ-011 anchoH  output  11  last measured HSync high width, in clocks.
REQ-012 lineasV  output  10  line count captured at the last VSync rising edge.
REQ-013 bloqueado  output  1  high while the line timing is locked.
REQ-014 errorSync  output  1  one-cycle pulse when lock is lost.

Function
REQ-015 Each sync input shall pass through a 2-flop synchronizer and then a registered edge detector; a rising edge is the synchronized value being 1 while its previous sample was 0.
REQ-016 On a detected HSync rising edge, cntHorizontalRec shall be 1 in the next cycle; otherwise it increments by 1 and saturates at 2047.
REQ-017 The width counter shall count cycles from a rising edge to the next falling edge; anchoH is loaded on the falling edge.
REQ-018 On each HSync rising edge except the first after BUSCAR, periodoH shall load the cycle count since the previous rising edge.
REQ-019 cntVerticalRec shall increment by 1 on each HSync rising edge and saturate at 1023.
REQ-020 On a VSync rising edge, lineasV shall load cntVerticalRec and cntVerticalRec shall clear to 0.
REQ-021 If both edges occur in the same cycle, the VSync clear takes priority.
REQ-022 FSM states: BUSCAR, MEDIR, BLOQUEADO.
REQ-023 BUSCAR shall move to MEDIR on the first HSync rising edge, with the match counter at 0.
REQ-024 In MEDIR, on each rising edge, a line matches when the new period equals PERIODO_H and the width measured for the previous line equals ANCHO_H.
REQ-025 In MEDIR, a matching line increments the match counter; a non-matching line clears it.
REQ-026 MEDIR shall move to BLOQUEADO when the match counter reaches LOCK_CNT.
REQ-027 In BLOQUEADO, a non-matching line shall pulse errorSync for one cycle and return the FSM to MEDIR with the match counter at 0.
REQ-028 Timeout: if cntHorizontalRec reaches 2047 in MEDIR or BLOQUEADO, the FSM shall go to BUSCAR; errorSync pulses only if leaving BLOQUEADO.
REQ-029 bloqueado shall be 1 exactly while the FSM is in BLOQUEADO, and shall be registered.

Reset
REQ-030 While reset is high, all outputs shall be 0 and the FSM shall be in BUSCAR; synchronizer flops and the match counter shall also be 0.
REQ-031 Asserting reset mid-line or mid-lock shall abandon the measurement; after release, relock requires the full LOCK_CNT sequence again.

Structure
REQ-032 A shared package vga_pkg shall hold PERIODO_H=1600, ANCHO_H=1408, counter widths (11 horizontal, 10 vertical) and the FSM state encoding.
REQ-033 One sub-module, sincronizador_flanco (2-flop synchronizer plus rising/falling edge outputs), shall be instantiated once for HSync and once for VSync.

Verification
REQ-034 Ideal HSync (period 1600, high 1408) -> periodoH=1600 and anchoH=1408; bloqueado=1 after the 3rd rising edge; cntHorizontalRec sequence is 1..1600, repeating.
REQ-035 While locked, a single line with period 1599 -> errorSync pulses once, bloqueado=0, and relock occurs after 2 further good lines.
REQ-036 While locked, HSync held low for 3000 clocks -> timeout to BUSCAR, one errorSync pulse, and cntHorizontalRec holds at 2047.
REQ-037 VSync pulsed after 525 HSync edges -> lineasV=525 and cntVerticalRec=0; coincident HSync/VSync edges -> cntVerticalRec=0.
REQ-038 Reset asserted for 1 cycle while locked -> all outputs 0 the next cycle; relock after 3 rising edges.
REQ-039 Width 1407 with period 1600 -> never locks, and anchoH=1407.

Source files
------------

// File: rtl/vga_sync_receiver_pkg.sv
// Shared constants and types for the VGA sync receiver: nominal line timing,
// counter widths and the lock FSM state encoding.
package vga_pkg;

    localparam int PERIODO_H = 1600;
    localparam int ANCHO_H   = 1408;

    localparam int H_W = 11;
    localparam int V_W = 10;

    localparam logic [H_W-1:0] H_MAX = '1;
    localparam logic [V_W-1:0] V_MAX = '1;

    typedef enum logic [1:0] {
        BUSCAR    = 2'd0,
        MEDIR     = 2'd1,
        BLOQUEADO = 2'd2
    } estado_t;

endpackage

// File: rtl/vga_sync_receiver_sincronizador_flanco.sv
// Brings one asynchronous sync line into the clk domain and reports its
// rising and falling edges as single-cycle strobes.
module sincronizador_flanco (
    input  logic clk,
    input  logic reset,
    input  logic senal_i,
    output logic subida_o,
    output logic bajada_o
);

    logic meta_q;
    logic sinc_q;
    logic prev_q;

    // Two-flop synchronizer followed by a one-sample history register for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sinc_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= senal_i;
            sinc_q <= meta_q;
            prev_q <= sinc_q;
        end
    end

    assign subida_o = sinc_q & ~prev_q;
    assign bajada_o = ~sinc_q & prev_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// Recovers the horizontal/vertical counters of an incoming VGA stream,
// measures line period and HSync width, and tracks lock to nominal timing.
module vga_sync_receiver #(
    parameter int PERIODO_H = vga_pkg::PERIODO_H,
    parameter int ANCHO_H   = vga_pkg::ANCHO_H,
    parameter int LOCK_CNT  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    HSync,
    input  logic                    VSync,
    output logic [vga_pkg::H_W-1:0] cntHorizontalRec,
    output logic [vga_pkg::V_W-1:0] cntVerticalRec,
    output logic [vga_pkg::H_W-1:0] periodoH,
    output logic [vga_pkg::H_W-1:0] anchoH,
    output logic [vga_pkg::V_W-1:0] lineasV,
    output logic                    bloqueado,
    output logic                    errorSync
);

    import vga_pkg::*;

    localparam int               MC_W   = $clog2(LOCK_CNT + 1);
    localparam logic [H_W-1:0]   PER_H  = H_W'(PERIODO_H);
    localparam logic [H_W-1:0]   ANC_H  = H_W'(ANCHO_H);
    localparam logic [MC_W-1:0]  LOCK_M = MC_W'(LOCK_CNT);

    logic hSubida, hBajada, vSubida;

    sincronizador_flanco uSincH (
        .clk      (clk),
        .reset    (reset),
        .senal_i  (HSync),
        .subida_o (hSubida),
        .bajada_o (hBajada)
    );

    sincronizador_flanco uSincV (
        .clk      (clk),
        .reset    (reset),
        .senal_i  (VSync),
        .subida_o (vSubida),
        .bajada_o ()
    );

    logic [H_W-1:0]  cntH_q, cntH_d;
    logic [V_W-1:0]  cntV_q, cntV_d;
    logic [H_W-1:0]  periodoH_q, periodoH_d;
    logic [H_W-1:0]  anchoH_q, anchoH_d;
    logic [V_W-1:0]  lineasV_q, lineasV_d;
    estado_t         estado_q, estado_d;
    logic [MC_W-1:0] matchCnt_q, matchCnt_d;
    logic            bloqueado_q, bloqueado_d;
    logic            errorSync_q, errorSync_d;
    logic            lineaOk;
    logic            timeout;

    // The horizontal counter doubles as the width counter: it restarts at the
    // rising edge, so its value at the falling edge is the high time.
    always_comb begin
        cntH_d     = (cntH_q == H_MAX) ? cntH_q : cntH_q + 1'b1;
        cntV_d     = cntV_q;
        periodoH_d = periodoH_q;
        anchoH_d   = anchoH_q;
        lineasV_d  = lineasV_q;
        if (hSubida) begin
            cntH_d = H_W'(1);
            if (cntV_q != V_MAX) begin
                cntV_d = cntV_q + 1'b1;
            end
            if (estado_q != BUSCAR) begin
                periodoH_d = cntH_q;
            end
        end
        if (hBajada) begin
            anchoH_d = cntH_q;
        end
        if (vSubida) begin
            lineasV_d = cntV_q;
            cntV_d    = '0;
        end
    end

    // A line matches when the period just ended and the width of that same line are nominal
    always_comb begin
        lineaOk     = (cntH_q == PER_H) && (anchoH_q == ANC_H);
        timeout     = (cntH_q == H_MAX);
        estado_d    = estado_q;
        matchCnt_d  = matchCnt_q;
        errorSync_d = 1'b0;
        case (estado_q)
            BUSCAR: begin
                if (hSubida) begin
                    estado_d   = MEDIR;
                    matchCnt_d = '0;
                end
            end
            MEDIR: begin
                if (timeout) begin
                    estado_d   = BUSCAR;
                    matchCnt_d = '0;
                end else if (hSubida) begin
                    if (lineaOk) begin
                        matchCnt_d = matchCnt_q + 1'b1;
                        if (matchCnt_d == LOCK_M) begin
                            estado_d = BLOQUEADO;
                        end
                    end else begin
                        matchCnt_d = '0;
                    end
                end
            end
            BLOQUEADO: begin
                if (timeout) begin
                    estado_d    = BUSCAR;
                    matchCnt_d  = '0;
                    errorSync_d = 1'b1;
                end else if (hSubida && !lineaOk) begin
                    estado_d    = MEDIR;
                    matchCnt_d  = '0;
                    errorSync_d = 1'b1;
                end
            end
            default: begin
                estado_d   = BUSCAR;
                matchCnt_d = '0;
            end
        endcase
        bloqueado_d = (estado_d == BLOQUEADO);
    end

    // State and measurement registers, all cleared by reset so a relock starts from scratch
    always_ff @(posedge clk) begin
        if (reset) begin
            cntH_q      <= '0;
            cntV_q      <= '0;
            periodoH_q  <= '0;
            anchoH_q    <= '0;
            lineasV_q   <= '0;
            estado_q    <= BUSCAR;
            matchCnt_q  <= '0;
            bloqueado_q <= 1'b0;
            errorSync_q <= 1'b0;
        end else begin
            cntH_q      <= cntH_d;
            cntV_q      <= cntV_d;
            periodoH_q  <= periodoH_d;
            anchoH_q    <= anchoH_d;
            lineasV_q   <= lineasV_d;
            estado_q    <= estado_d;
            matchCnt_q  <= matchCnt_d;
            bloqueado_q <= bloqueado_d;
            errorSync_q <= errorSync_d;
        end
    end

    assign cntHorizontalRec = cntH_q;
    assign cntVerticalRec   = cntV_q;
    assign periodoH         = periodoH_q;
    assign anchoH           = anchoH_q;
    assign lineasV          = lineasV_q;
    assign bloqueado        = bloqueado_q;
    assign errorSync        = errorSync_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver: lock acquisition, loss of lock,
// timeout, vertical counting and reset behaviour.
module tb_vga_sync_receiver;

    logic        clk;
    logic        reset;
    logic        HSync;
    logic        VSync;
    logic [10:0] cntHorizontalRec;
    logic [9:0]  cntVerticalRec;
    logic [10:0] periodoH;
    logic [10:0] anchoH;
    logic [9:0]  lineasV;
    logic        bloqueado;
    logic        errorSync;

    int testCount = 0;
    int failCount = 0;
    int errPulses = 0;
    int errBase;
    int badSeq;

    vga_sync_receiver dut (
        .clk              (clk),
        .reset            (reset),
        .HSync            (HSync),
        .VSync            (VSync),
        .cntHorizontalRec (cntHorizontalRec),
        .cntVerticalRec   (cntVerticalRec),
        .periodoH         (periodoH),
        .anchoH           (anchoH),
        .lineasV          (lineasV),
        .bloqueado        (bloqueado),
        .errorSync        (errorSync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every cycle errorSync is seen high, so a stretched pulse shows up as extra pulses
    always @(negedge clk) begin
        if (errorSync === 1'b1) errPulses++;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One HSync line: high for 'width' clocks, low for the rest of 'period'
    task automatic applyStimulus(input int period, input int width);
        for (int i = 0; i < period; i++) begin
            @(negedge clk);
            HSync = (i < width);
        end
    endtask

    task automatic holdLow(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            HSync = 1'b0;
        end
    endtask

    task automatic pulseVSync();
        @(negedge clk);
        VSync = 1'b1;
        repeat (3) @(negedge clk);
        VSync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_cntH"}, cntHorizontalRec, 0);
        checkOutput({tag, "_cntV"}, cntVerticalRec, 0);
        checkOutput({tag, "_periodoH"}, periodoH, 0);
        checkOutput({tag, "_anchoH"}, anchoH, 0);
        checkOutput({tag, "_lineasV"}, lineasV, 0);
        checkOutput({tag, "_bloqueado"}, bloqueado, 0);
        checkOutput({tag, "_errorSync"}, errorSync, 0);
    endtask

    initial begin
        reset = 1'b1;
        HSync = 1'b0;
        VSync = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Ideal lines: lock after the third rising edge
        applyStimulus(1600, 1408);
        checkOutput("l1_periodoH_first_edge_not_loaded", periodoH, 0);
        checkOutput("l1_anchoH", anchoH, 1408);
        checkOutput("l1_bloqueado", bloqueado, 0);
        applyStimulus(1600, 1408);
        checkOutput("l2_periodoH", periodoH, 1600);
        checkOutput("l2_bloqueado", bloqueado, 0);
        applyStimulus(1600, 1408);
        checkOutput("l3_bloqueado", bloqueado, 1);

        // Fourth line sampled every cycle: counter runs 1..1600
        badSeq = 0;
        for (int k = 0; k < 1600; k++) begin
            @(negedge clk);
            if (k == 2) checkOutput("seq_top_1600", cntHorizontalRec, 1600);
            if (k == 3) checkOutput("seq_wrap_1", cntHorizontalRec, 1);
            if (int'(cntHorizontalRec) != ((k + 1597) % 1600) + 1) badSeq++;
            HSync = (k < 1408);
        end
        checkOutput("seq_bad_samples", badSeq, 0);
        checkOutput("l4_bloqueado", bloqueado, 1);
        checkOutput("l4_no_error", errPulses, 0);

        // One short line while locked
        errBase = errPulses;
        applyStimulus(1599, 1408);
        applyStimulus(1600, 1408);
        checkOutput("short_bloqueado", bloqueado, 0);
        checkOutput("short_periodoH", periodoH, 1599);
        checkOutput("short_err_pulses", errPulses - errBase, 1);
        applyStimulus(1600, 1408);
        checkOutput("relock1_bloqueado", bloqueado, 0);
        applyStimulus(1600, 1408);
        checkOutput("relock2_bloqueado", bloqueado, 1);

        // HSync lost while locked
        errBase = errPulses;
        holdLow(3000);
        checkOutput("timeout_cntH", cntHorizontalRec, 2047);
        checkOutput("timeout_bloqueado", bloqueado, 0);
        checkOutput("timeout_err_pulses", errPulses - errBase, 1);

        // Vertical counting: 8 full lines so far, then 525 short lines
        pulseVSync();
        checkOutput("v0_lineasV", lineasV, 8);
        checkOutput("v0_cntV", cntVerticalRec, 0);
        for (int n = 0; n < 525; n++) applyStimulus(8, 4);
        checkOutput("v525_cntV", cntVerticalRec, 525);
        pulseVSync();
        checkOutput("v525_lineasV", lineasV, 525);
        checkOutput("v525_cntV_cleared", cntVerticalRec, 0);
        for (int n = 0; n < 1030; n++) applyStimulus(8, 4);
        checkOutput("v_saturate", cntVerticalRec, 1023);

        // Coincident edges: clear wins over increment
        @(negedge clk);
        HSync = 1'b1;
        VSync = 1'b1;
        repeat (4) @(negedge clk);
        HSync = 1'b0;
        VSync = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("coinc_cntV", cntVerticalRec, 0);
        checkOutput("coinc_lineasV", lineasV, 1023);

        // Lock again, then a single reset cycle
        applyStimulus(1600, 1408);
        applyStimulus(1600, 1408);
        applyStimulus(1600, 1408);
        checkOutput("prereset_bloqueado", bloqueado, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkAllZero("midlock_reset");
        reset = 1'b0;
        applyStimulus(1600, 1408);
        applyStimulus(1600, 1408);
        checkOutput("postreset2_bloqueado", bloqueado, 0);
        applyStimulus(1600, 1408);
        checkOutput("postreset3_bloqueado", bloqueado, 1);
        checkOutput("postreset3_periodoH", periodoH, 1600);

        // Width one clock short never locks
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        errBase = errPulses;
        for (int n = 0; n < 5; n++) begin
            applyStimulus(1600, 1407);
            checkOutput($sformatf("narrow%0d_bloqueado", n), bloqueado, 0);
        end
        checkOutput("narrow_anchoH", anchoH, 1407);
        checkOutput("narrow_periodoH", periodoH, 1600);
        checkOutput("narrow_no_error", errPulses - errBase, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
